seven_seg_scan_decoder: RTL and testbench

- Receive side of the multiplexed seven-segment display interface. It watches the scanned segment bus and the digit-strobe bus that a display driver produces.
- Each digit is qualified for stability, then its segment pattern is decoded back to a hex nibble.
- A complete 4-digit frame is reassembled into a 16-bit value.
- Used as an on-board or bench-side monitor to check display drivers (e.g. counter-to-display paths) without inspecting waveforms by eye.

---
 rtl/seven_seg_scan_decoder.sv | 175 +++++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed segment/strobe bus,
// qualifies each digit for stability, decodes the glyph back to a hex nibble
// and reassembles complete 4-digit frames into a 16-bit value.
//
// state | meaning
// IDLE  | strobe blank or multi-hot, nothing being qualified
// QUAL  | counting consecutive identical {segments, strobe} samples
// HELD  | current sample already qualified, waiting for it to change
module seven_seg_scan_decoder #(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1,
  parameter int unsigned STABLE_CYCLES  = 4
) (
  input  logic        in_clk,
  input  logic        rst,
  input  logic [7:0]  Seven_Seg,
  input  logic [3:0]  digit,
  output logic [15:0] value,
  output logic [3:0]  dp_out,
  output logic        valid,
  output logic        frame_done,
  output logic        err_seg,
  output logic        err_digit
);

  // Counter value at which one more identical sample completes qualification.
  localparam logic [7:0] QUAL_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       cnt;
  logic [7:0]       seg_s;
  logic [3:0]       dig_s;
  logic [7:0]       seg_prev;
  logic [3:0]       dig_prev;
  logic [3:0]       mask;
  logic [3:0][3:0]  slot_nib;
  logic [3:0]       slot_dp;

  logic             dig_onehot;
  logic             dig_multi;
  logic             same;
  logic [3:0]       dec_nib;
  logic             dec_legal;
  logic [3:0][3:0]  asm_nib;
  logic [3:0]       asm_dp;
  logic [3:0]       mask_next;

  // Register the raw buses and fold both polarities to active-high.
  always_ff @(posedge in_clk) begin
    if (rst) begin
      seg_s <= 8'h00;
      dig_s <= 4'h0;
    end else begin
      seg_s <= SEG_ACTIVE_LOW ? ~Seven_Seg : Seven_Seg;
      dig_s <= DIG_ACTIVE_LOW ? ~digit : digit;
    end
  end

  // Strobe classification and sample-to-sample comparison.
  always_comb begin
    dig_onehot = (dig_s != 4'h0) && ((dig_s & (dig_s - 4'd1)) == 4'h0);
    dig_multi  = (dig_s != 4'h0) && !dig_onehot;
    same       = (seg_s == seg_prev) && (dig_s == dig_prev);
  end

  // Glyph decode of the active-high gfedcba pattern; dp is not part of it.
  always_comb begin
    dec_legal = 1'b1;
    dec_nib   = 4'h0;
    case (seg_s[6:0])
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  // Slot contents as they would be after writing the current sample; the
  // one-hot strobe doubles as the slot write enable and the new mask bit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      asm_nib[i] = dig_s[i] ? dec_nib  : slot_nib[i];
      asm_dp[i]  = dig_s[i] ? seg_s[7] : slot_dp[i];
    end
    mask_next = mask | dig_s;
  end

  // Qualification FSM, slot storage and frame assembly with registered outputs.
  always_ff @(posedge in_clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      seg_prev   <= 8'h00;
      dig_prev   <= 4'h0;
      mask       <= 4'h0;
      slot_nib   <= '0;
      slot_dp    <= 4'h0;
      value      <= 16'h0000;
      dp_out     <= 4'h0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      err_seg    <= 1'b0;
      err_digit  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_seg    <= 1'b0;
      err_digit  <= dig_multi;
      seg_prev   <= seg_s;
      dig_prev   <= dig_s;
      case (state)
        IDLE: begin
          if (dig_onehot) begin
            cnt   <= 8'd1;
            state <= QUAL;
          end
        end
        QUAL: begin
          if (!dig_onehot) begin
            state <= IDLE;
          end else if (!same) begin
            cnt <= 8'd1;
          end else if (cnt == QUAL_LAST) begin
            state <= HELD;
            if (dec_legal) begin
              slot_nib <= asm_nib;
              slot_dp  <= asm_dp;
              if (mask_next == 4'hF) begin
                value      <= asm_nib;
                dp_out     <= asm_dp;
                frame_done <= 1'b1;
                valid      <= 1'b1;
                mask       <= 4'h0;
              end else begin
                mask <= mask_next;
              end
            end else begin
              err_seg <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HELD: begin
          if (!dig_onehot) begin
            state <= IDLE;
          end else if (!same) begin
            cnt   <= 8'd1;
            state <= QUAL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed scenarios plus random scanning,
// compared every cycle against a run-length based reference model.
module tb_seven_seg_scan_decoder;

  localparam int STABLE = 4;

  logic        in_clk;
  logic        rst;
  logic [7:0]  Seven_Seg;
  logic [3:0]  digit;
  logic [15:0] value;
  logic [3:0]  dp_out;
  logic        valid;
  logic        frame_done;
  logic        err_seg;
  logic        err_digit;

  seven_seg_scan_decoder #(
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .in_clk(in_clk),
    .rst(rst),
    .Seven_Seg(Seven_Seg),
    .digit(digit),
    .value(value),
    .dp_out(dp_out),
    .valid(valid),
    .frame_done(frame_done),
    .err_seg(err_seg),
    .err_digit(err_digit)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Active-high gfedcba glyph for each hex digit.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state: registered sample, run length of identical samples.
  logic [7:0]  m_seg;
  logic [3:0]  m_dig;
  logic [11:0] m_prev;
  int          m_run;
  logic [3:0]  m_slot [4];
  logic        m_sdp  [4];
  logic [3:0]  m_mask;
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic        m_valid, m_fd, m_es, m_ed;

  int fd_cnt, es_cnt, ed_cnt;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_seg = 8'h00; m_dig = 4'h0; m_prev = 12'h000; m_run = 0;
    for (int i = 0; i < 4; i++) begin m_slot[i] = 4'h0; m_sdp[i] = 1'b0; end
    m_mask = 4'h0; m_value = 16'h0; m_dp = 4'h0;
    m_valid = 1'b0; m_fd = 1'b0; m_es = 1'b0; m_ed = 1'b0;
  endtask

  // One rising edge: consume the previously registered sample, then register the new inputs.
  task automatic model_step(input logic r, input logic [7:0] seg_raw, input logic [3:0] dig_raw);
    int idx, nib;
    if (r) begin
      model_clear();
      return;
    end
    m_fd = 1'b0;
    m_es = 1'b0;
    m_ed = (m_dig != 4'h0) && ($countones(m_dig) != 1);
    if ($countones(m_dig) == 1) begin
      if (m_run > 0 && {m_seg, m_dig} == m_prev) m_run++;
      else m_run = 1;
      if (m_run == STABLE) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (m_dig[i]) idx = i;
        nib = -1;
        for (int g = 0; g < 16; g++) if (glyph[g] == m_seg[6:0]) nib = g;
        if (nib < 0) begin
          m_es = 1'b1;
        end else begin
          m_slot[idx] = 4'(nib);
          m_sdp[idx]  = m_seg[7];
          m_mask[idx] = 1'b1;
          if (m_mask == 4'hF) begin
            m_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            m_dp    = {m_sdp[3], m_sdp[2], m_sdp[1], m_sdp[0]};
            m_fd    = 1'b1;
            m_valid = 1'b1;
            m_mask  = 4'h0;
          end
        end
      end
    end else begin
      m_run = 0;
    end
    m_prev = {m_seg, m_dig};
    m_seg  = ~seg_raw;
    m_dig  = ~dig_raw;
  endtask

  task automatic cycle(input logic r, input logic [7:0] seg_raw, input logic [3:0] dig_raw);
    rst = r;
    Seven_Seg = seg_raw;
    digit = dig_raw;
    @(posedge in_clk);
    model_step(r, seg_raw, dig_raw);
    @(negedge in_clk);
    check("value", value, m_value);
    check("dp_out", {12'h0, dp_out}, {12'h0, m_dp});
    check("valid", {15'h0, valid}, {15'h0, m_valid});
    check("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
    check("err_seg", {15'h0, err_seg}, {15'h0, m_es});
    check("err_digit", {15'h0, err_digit}, {15'h0, m_ed});
    fd_cnt += int'(frame_done);
    es_cnt += int'(err_seg);
    ed_cnt += int'(err_digit);
  endtask

  task automatic hold(input logic [7:0] seg_raw, input logic [3:0] dig_raw, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, seg_raw, dig_raw);
  endtask

  task automatic do_reset();
    cycle(1'b1, 8'hFF, 4'hF);
    cycle(1'b1, 8'hFF, 4'hF);
    fd_cnt = 0; es_cnt = 0; ed_cnt = 0;
  endtask

  initial begin
    logic [7:0] sg;
    logic [3:0] dg;
    int len;
    model_clear();
    fd_cnt = 0; es_cnt = 0; ed_cnt = 0;
    rst = 1'b1; Seven_Seg = 8'hFF; digit = 4'hF;

    // reset state
    do_reset();
    check("rst_value", value, 16'h0000);
    check("rst_valid", {15'h0, valid}, 16'h0000);

    // defaults: 0,1,2,3 across the four slots
    hold(8'hC0, 4'b1110, 8);
    hold(8'hF9, 4'b1101, 8);
    hold(8'hA4, 4'b1011, 8);
    hold(8'hB0, 4'b0111, 8);
    hold(8'hFF, 4'hF, 2);
    check("dflt_frames", 16'(fd_cnt), 16'd1);
    check("dflt_value", value, 16'h3210);
    check("dflt_dp", {12'h0, dp_out}, 16'h0000);
    check("dflt_valid", {15'h0, valid}, 16'h0001);

    // glitch filter: 3 cycles rejected, 4 cycles accepted
    do_reset();
    hold(8'h8E, 4'b1110, 3);
    hold(8'hFF, 4'hF, 2);
    hold(8'hF9, 4'b1101, 6);
    hold(8'hA4, 4'b1011, 6);
    hold(8'hB0, 4'b0111, 6);
    hold(8'hFF, 4'hF, 2);
    check("glitch_noframe", 16'(fd_cnt), 16'd0);
    hold(8'h8E, 4'b1110, 3);
    check("glitch_edge3", 16'(fd_cnt), 16'd0);
    hold(8'h8E, 4'b1110, 1);
    hold(8'hFF, 4'hF, 1);
    check("glitch_edge4", 16'(fd_cnt), 16'd1);
    check("glitch_value", value, 16'h321F);

    // illegal glyph: only segment a lit
    do_reset();
    hold(8'hFF ^ 8'h01, 4'b1101, 6);
    hold(8'hFF, 4'hF, 2);
    check("illegal_errseg", 16'(es_cnt), 16'd1);
    check("illegal_noframe", 16'(fd_cnt), 16'd0);

    // multi-hot strobe
    do_reset();
    hold(8'hC0, 4'b1100, 5);
    hold(8'hFF, 4'hF, 2);
    check("multihot_errdig", 16'(ed_cnt), 16'd5);
    check("multihot_noframe", 16'(fd_cnt), 16'd0);

    // overwrite and decimal point
    do_reset();
    hold(8'h92, 4'b1110, 6);
    hold(8'hF8, 4'b1110, 6);
    hold(8'hF9, 4'b1101, 6);
    hold(8'hA4, 4'b1011, 6);
    hold(8'h30, 4'b0111, 6);
    hold(8'hFF, 4'hF, 2);
    check("ovw_frames", 16'(fd_cnt), 16'd1);
    check("ovw_value", value, 16'h3217);
    check("ovw_dp", {12'h0, dp_out}, 16'h0008);

    // reset mid-frame discards partial slots
    do_reset();
    hold(8'hC0, 4'b1110, 6);
    hold(8'hF9, 4'b1101, 6);
    hold(8'hA4, 4'b1011, 6);
    cycle(1'b1, 8'hFF, 4'hF);
    hold(8'hB0, 4'b0111, 6);
    hold(8'hFF, 4'hF, 2);
    check("midrst_noframe", 16'(fd_cnt), 16'd0);
    check("midrst_value", value, 16'h0000);
    check("midrst_valid", {15'h0, valid}, 16'h0000);

    // random scanning against the reference model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      len = $urandom_range(1, 8);
      case ($urandom_range(0, 9))
        0:       dg = 4'hF;
        1:       dg = 4'($urandom);
        default: dg = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 7) == 0) sg = 8'($urandom);
      else sg = ~{1'($urandom), glyph[$urandom_range(0, 15)]};
      if ($urandom_range(0, 99) == 0) cycle(1'b1, sg, dg);
      hold(sg, dg, len);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
